// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the fetch / prefetch-queue slice.
//   - FSM state constants (IDLE: free to issue, WAIT: one request outstanding)
//   - default NOP instruction
//   - queue entry layout {instr, npc} at the default 16/16 widths
package fetch_prefetch_queue_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  localparam int ENT_DATA_W = 16;
  localparam int ENT_ADDR_W = 16;

  typedef struct packed {
    logic [ENT_DATA_W-1:0] instr;
    logic [ENT_ADDR_W-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_queue.sv
// fetch_queue: synchronous FIFO holding prefetched {instr, npc} entries.
//   clk, rst   clock, synchronous active-low reset
//   push/pop   enqueue wdata / drop head (caller never pops empty or pushes full)
//   flush      empties the queue; wins over push/pop in the same cycle
//   rdata      head entry (undefined when count==0)
//   count      number of valid entries, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (rst && push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: fetch stage decoupling a stalling instruction memory
// from decode through a DEPTH-entry queue of {instr, pc+INCR}.
//   clk, rst                 clock, synchronous active-low reset
//   halt                     stop issuing; queue keeps draining
//   do_branch, branch_pc     redirect + flush; outstanding response discarded
//   haz_stall                hold head entry
//   mem_rd/mem_addr          request to memory; mem_stall = not accepted
//   mem_done/mem_data/mem_err response (one outstanding request max)
//   instr/next_pc/instr_valid head entry presented to decode
//   fetch_busy               request outstanding
//   fetch_err                sticky fetch error (only with FETCH_ERR_TRAP_EN)
// Optional feature macro: FETCH_ERR_TRAP_EN (error trap; otherwise mem_err is ignored).
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int               DATA_W    = 16,
  parameter int               ADDR_W    = 16,
  parameter int               DEPTH     = 4,
  parameter int               INCR      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              do_branch,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic              haz_stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_err,
`ifdef FETCH_ERR_TRAP_EN
  output logic              fetch_err,
`endif
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] next_pc,
  output logic              instr_valid,
  output logic              fetch_busy
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] last_npc_q, last_npc_d;
  logic              epoch_q, epoch_d, req_epoch_q, req_epoch_d;
  logic              trap;

  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_head, q_wdata;
  logic [DATA_W-1:0] q_wdata_instr;
  logic              accept, resp_ok, resp_live, q_push, q_pop;

  fetch_queue #(.DEPTH(DEPTH), .W(ENT_W)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (do_branch),
    .wdata (q_wdata),
    .rdata (q_head),
    .count (q_count)
  );

`ifdef FETCH_ERR_TRAP_EN
  logic err_q, err_d;
  assign trap          = err_q;
  assign fetch_err     = err_q;
  assign err_d         = err_q | (resp_ok & mem_err);
  assign q_wdata_instr = mem_err ? NOP_INSTR : mem_data;
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`else
  logic unused_mem_err;
  assign unused_mem_err = mem_err;
  assign trap           = 1'b0;
  assign q_wdata_instr  = mem_data;
`endif

  // Issue only with a free slot so the single response can always enqueue.
  assign mem_rd   = rst & (state_q == ST_IDLE) & ~halt & ~do_branch & ~trap &
                    (q_count < CNT_W'(DEPTH));
  assign mem_addr = fetch_pc_q;
  assign accept   = mem_rd & ~mem_stall;

  assign resp_live = (req_epoch_q == epoch_q);
  assign resp_ok   = (state_q == ST_WAIT) & mem_done & resp_live & ~do_branch;
  assign q_push    = resp_ok;
  assign q_wdata   = {q_wdata_instr, req_pc_q + ADDR_W'(INCR)};

  assign instr_valid = (q_count != '0) & ~do_branch;
  assign q_pop       = instr_valid & ~haz_stall;
  assign instr       = instr_valid ? q_head[ENT_W-1:ADDR_W] : NOP_INSTR;
  assign next_pc     = instr_valid ? q_head[ADDR_W-1:0] : last_npc_q;
  assign fetch_busy  = (state_q == ST_WAIT);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_epoch_d = req_epoch_q;
    epoch_d     = epoch_q;
    last_npc_d  = instr_valid ? q_head[ADDR_W-1:0] : last_npc_q;

    if (state_q == ST_WAIT && mem_done) state_d = ST_IDLE;

    if (accept) begin
      state_d     = ST_WAIT;
      req_pc_d    = fetch_pc_q;
      req_epoch_d = epoch_q;
      fetch_pc_d  = fetch_pc_q + ADDR_W'(INCR);
    end

    // Toggle only while the outstanding response is still live, so a second
    // redirect during the same WAIT cannot flip the epoch back into a match.
    if (do_branch) begin
      fetch_pc_d = branch_pc;
      if (state_q == ST_WAIT && resp_live) epoch_d = ~epoch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      last_npc_q  <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_epoch_q <= req_epoch_d;
      epoch_q     <= epoch_d;
      last_npc_q  <= last_npc_d;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;
  import fetch_prefetch_queue_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [15:0] NOP   = 16'h0800;

  logic        clk = 1'b0;
  logic        rst, halt, do_branch, haz_stall, mem_stall, mem_done, mem_err;
  logic [15:0] branch_pc, mem_data, mem_addr, instr, next_pc;
  logic        mem_rd, instr_valid, fetch_busy;
`ifdef FETCH_ERR_TRAP_EN
  logic        fetch_err;
`endif

  fetch_prefetch_queue dut (
    .clk(clk), .rst(rst), .halt(halt), .do_branch(do_branch), .branch_pc(branch_pc),
    .haz_stall(haz_stall), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_stall(mem_stall),
    .mem_done(mem_done), .mem_data(mem_data), .mem_err(mem_err),
`ifdef FETCH_ERR_TRAP_EN
    .fetch_err(fetch_err),
`endif
    .instr(instr), .next_pc(next_pc), .instr_valid(instr_valid), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Reference model: queue contents, PC, and an "outstanding / stale" view of memory.
  fetch_entry_t mq[$];
  logic [15:0]  m_pc = 0, m_req_pc = 0, m_last_npc = 0;
  bit           m_out = 0, m_stale = 0, m_err = 0;
  int           lat = 0;
  int           p_halt, p_br, p_haz, p_stall, p_spur, p_err, lat_max;

  logic         exp_rd, exp_valid, exp_busy;
  logic [15:0]  exp_addr, exp_instr, exp_npc;

  function automatic bit roll(int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [50:0] act_v();
    return {mem_rd, mem_addr, instr_valid, instr, next_pc, fetch_busy};
  endfunction

  function automatic logic [50:0] exp_v();
    return {exp_rd, exp_addr, exp_valid, exp_instr, exp_npc, exp_busy};
  endfunction

  task automatic knobs(int h, int b, int z, int s, int sp, int e, int l);
    p_halt = h; p_br = b; p_haz = z; p_stall = s; p_spur = sp; p_err = e; lat_max = l;
  endtask

  task automatic rand_inputs();
    rst       = 1'b1;
    halt      = roll(p_halt);
    do_branch = roll(p_br);
    branch_pc = 16'($urandom) & 16'hFFFE;
    haz_stall = roll(p_haz);
    mem_stall = roll(p_stall);
    mem_data  = 16'($urandom);
    mem_err   = roll(p_err);
    mem_done  = m_out ? (lat == 0) : roll(p_spur);
  endtask

  task automatic predict();
    exp_valid = (mq.size() != 0) && !do_branch;
    exp_instr = NOP;
    exp_npc   = m_last_npc;
    if (exp_valid) begin
      exp_instr = mq[0].instr;
      exp_npc   = mq[0].npc;
    end
    exp_rd   = rst && !m_out && !halt && !do_branch && mq.size() < DEPTH && !m_err;
    exp_addr = m_pc;
    exp_busy = m_out;
  endtask

  task automatic advance();
    fetch_entry_t e;
    @(posedge clk);
    if (!rst) begin
      mq.delete(); m_pc = 0; m_out = 0; m_stale = 0; m_last_npc = 0; m_err = 0;
    end else begin
      if (m_out && !mem_done && lat > 0) lat--;
      if (exp_valid) m_last_npc = mq[0].npc;
      if (do_branch) begin
        mq.delete();
        m_pc = branch_pc;
        if (m_out) begin
          if (mem_done) m_out = 0;
          else          m_stale = 1;
        end
      end else begin
        if (exp_valid && !haz_stall) void'(mq.pop_front());
        if (m_out && mem_done) begin
          m_out = 0;
          if (!m_stale) begin
            e.instr = mem_data;
            e.npc   = m_req_pc + 16'd2;
`ifdef FETCH_ERR_TRAP_EN
            if (mem_err) begin e.instr = NOP; m_err = 1; end
`endif
            mq.push_back(e);
          end
          m_stale = 0;
        end
        if (exp_rd && !mem_stall) begin
          m_out = 1; m_stale = 0; m_req_pc = m_pc; m_pc = m_pc + 16'd2;
          lat = $urandom_range(0, lat_max);
        end
      end
    end
  endtask

  task automatic test_reset();
    knobs(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rand_inputs(); rst = 1'b0; mem_done = 1'b1; predict(); #1;
      if (i > 0) begin
        n_chk++;
        if (act_v() !== exp_v()) $display("FAIL reset cyc%0d: got %h want %h", i, act_v(), exp_v());
        else n_pass++;
      end
      if (i == 2) begin
        n_chk++;
        if ({mem_rd, instr, next_pc, instr_valid, fetch_busy} !== {1'b0, 16'h0800, 16'h0, 2'b00})
          $display("FAIL reset_outputs: got %h want %h",
                   {mem_rd, instr, next_pc, instr_valid, fetch_busy}, {1'b0, 16'h0800, 16'h0, 2'b00});
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_stream();
    int first_rd = -1, first_vld = -1, k = 0;
    knobs(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); rand_inputs(); predict(); #1;
      n_chk++;
      if (act_v() !== exp_v()) $display("FAIL stream cyc%0d: got %h want %h", i, act_v(), exp_v());
      else n_pass++;
      if (mem_rd === 1'b1) begin
        if (first_rd < 0) first_rd = i;
        n_chk++;
        if (mem_addr !== 16'(2 * k)) $display("FAIL stream_addr #%0d: got %h want %h", k, mem_addr, 16'(2 * k));
        else n_pass++;
        k++;
      end
      if (instr_valid === 1'b1 && first_vld < 0) first_vld = i;
      advance();
    end
    n_chk++;
    if (first_vld - first_rd != 2) $display("FAIL stream_latency: got %0d want 2", first_vld - first_rd);
    else n_pass++;
  endtask

  task automatic test_haz_fill();
    knobs(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); rand_inputs(); haz_stall = (i < 12); predict(); #1;
      n_chk++;
      if (act_v() !== exp_v()) $display("FAIL haz_fill cyc%0d: got %h want %h", i, act_v(), exp_v());
      else n_pass++;
      if (i == 11) begin
        n_chk++;
        if ({mem_rd, instr_valid} !== 2'b01) $display("FAIL haz_full: got rd/vld %b want 01", {mem_rd, instr_valid});
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic wait_wait_state(input string nm, input int lmin);
    int k = 0;
    while (!(m_out && lat >= lmin) && k < 40) begin
      @(negedge clk); rand_inputs(); predict(); #1;
      n_chk++;
      if (act_v() !== exp_v()) $display("FAIL %s_pre cyc%0d: got %h want %h", nm, k, act_v(), exp_v());
      else n_pass++;
      advance(); k++;
    end
    if (k == 40) begin n_chk++; $display("FAIL %s_timeout: got no WAIT want WAIT", nm); end
  endtask

  task automatic test_branch();
    int k = 0;
    knobs(0, 0, 0, 0, 0, 0, 3);
    wait_wait_state("branch", 1);
    @(negedge clk); rand_inputs(); do_branch = 1'b1; branch_pc = 16'h0040; predict(); #1;
    n_chk++;
    if (act_v() !== exp_v() || instr !== 16'h0800 || instr_valid !== 1'b0)
      $display("FAIL branch_cycle: got %h want %h", act_v(), exp_v());
    else n_pass++;
    advance();
    knobs(0, 0, 0, 0, 0, 0, 0);
    while (k < 12) begin
      @(negedge clk); rand_inputs(); predict(); #1;
      n_chk++;
      if (act_v() !== exp_v()) $display("FAIL branch_post cyc%0d: got %h want %h", k, act_v(), exp_v());
      else n_pass++;
      if (mem_rd === 1'b1) break;
      advance(); k++;
    end
    n_chk++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0040) $display("FAIL branch_target: got %h want 0040", mem_addr);
    else n_pass++;
    advance();
  endtask

  task automatic test_branch_done();
    int k = 0;
    knobs(0, 0, 0, 0, 0, 0, 3);
    while (!(mq.size() == DEPTH - 1 && m_out) && k < 40) begin
      @(negedge clk); rand_inputs(); haz_stall = 1'b1; predict(); #1;
      n_chk++;
      if (act_v() !== exp_v()) $display("FAIL brdone_fill cyc%0d: got %h want %h", k, act_v(), exp_v());
      else n_pass++;
      advance(); k++;
    end
    if (k == 40) begin n_chk++; $display("FAIL brdone_timeout: got no fill want fill"); end
    @(negedge clk); rand_inputs();
    haz_stall = 1'b0; do_branch = 1'b1; branch_pc = 16'h0100; mem_done = 1'b1; predict(); #1;
    n_chk++;
    if (act_v() !== exp_v()) $display("FAIL brdone_cycle: got %h want %h", act_v(), exp_v());
    else n_pass++;
    advance();
    @(negedge clk); rand_inputs(); predict(); #1;
    n_chk++;
    if ({instr_valid, mem_rd, mem_addr} !== {2'b01, 16'h0100})
      $display("FAIL brdone_after: got %h want %h", {instr_valid, mem_rd, mem_addr}, {2'b01, 16'h0100});
    else n_pass++;
    advance();
  endtask

  task automatic test_halt_reset();
    knobs(0, 0, 0, 0, 0, 0, 3);
    wait_wait_state("halt", 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rand_inputs(); halt = 1'b1; predict(); #1;
      n_chk++;
      if (act_v() !== exp_v() || mem_rd !== 1'b0) $display("FAIL halt cyc%0d: got %h want %h", i, act_v(), exp_v());
      else n_pass++;
      advance();
    end
    wait_wait_state("rstwait", 0);
    @(negedge clk); rand_inputs(); rst = 1'b0; halt = 1'b1; mem_done = 1'b0; predict(); #1; advance();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rand_inputs(); halt = 1'b1; mem_done = (i == 0); predict(); #1;
      n_chk++;
      if (act_v() !== exp_v() || {instr_valid, fetch_busy} !== 2'b00)
        $display("FAIL late_done cyc%0d: got %h want %h", i, act_v(), exp_v());
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
`ifdef FETCH_ERR_TRAP_EN
    knobs(10, 5, 30, 30, 5, 0, 3);
`else
    knobs(10, 5, 30, 30, 5, 20, 3);
`endif
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); rand_inputs(); predict(); #1;
      n_chk++;
      if (act_v() !== exp_v()) $display("FAIL random cyc%0d: got %h want %h", i, act_v(), exp_v());
      else n_pass++;
      advance();
    end
  endtask

`ifdef FETCH_ERR_TRAP_EN
  task automatic test_err();
    knobs(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rand_inputs(); rst = 1'b0; predict(); #1; advance();
    wait_wait_state("err", 0);
    @(negedge clk); rand_inputs(); mem_err = 1'b1; predict(); #1; advance();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rand_inputs(); do_branch = (i == 4); predict(); #1;
      n_chk++;
      if (act_v() !== exp_v() || fetch_err !== 1'b1 || mem_rd !== 1'b0)
        $display("FAIL err cyc%0d: got %h/%b want %h/1", i, act_v(), fetch_err, exp_v());
      else n_pass++;
      if (i == 0) begin
        n_chk++;
        if ({instr_valid, instr} !== {1'b1, 16'h0800}) $display("FAIL err_nop: got %h want 10800", {instr_valid, instr});
        else n_pass++;
      end
      advance();
    end
  endtask
`endif

  initial begin
    rst = 1'b0; halt = 0; do_branch = 0; branch_pc = 0; haz_stall = 0;
    mem_stall = 0; mem_done = 0; mem_data = 0; mem_err = 0;
    test_reset();
    test_stream();
    test_haz_fill();
    test_branch();
    test_branch_done();
    test_halt_reset();
    test_random();
`ifdef FETCH_ERR_TRAP_EN
    test_err();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
